// File: rtl/icache_pkg.sv
// Shared types, constants and width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned IMISS_BIT = 32;

  function automatic int unsigned woff_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned line_words,
                                            input int unsigned num_lines);
    return 32 - 2 - woff_width(line_words) - idx_width(num_lines);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one synchronous write port, one asynchronous read port.
module icache_data_ram #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Refill beats land here; the array has no reset.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache with combinational lookup and a line refill FSM.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Icache_addr_in,
  output logic [32:0] Icache_bus_out,
  input  logic        i_inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WOFF_W = woff_width(LINE_WORDS);
  localparam int unsigned IDX_W  = idx_width(NUM_LINES);
  localparam int unsigned TAG_W  = tag_width(LINE_WORDS, NUM_LINES);

  // Lookup address fields
  logic [WOFF_W-1:0] a_word;
  logic [IDX_W-1:0]  a_idx;
  logic [TAG_W-1:0]  a_tag;
  logic              addr_lsb_unused;

  assign a_word          = Icache_addr_in[WOFF_W+1:2];
  assign a_idx           = Icache_addr_in[IDX_W+WOFF_W+1:WOFF_W+2];
  assign a_tag           = Icache_addr_in[31:32-TAG_W];
  assign addr_lsb_unused = ^Icache_addr_in[1:0];

  // Refill target fields come from the latched line address; the word bits
  // of mem_addr advance in lock-step with cnt_q, so index and tag stay fixed.
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;

  assign r_idx = mem_addr[IDX_W+WOFF_W+1:WOFF_W+2];
  assign r_tag = mem_addr[31:32-TAG_W];

  state_t            state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q [NUM_LINES];
  logic [WOFF_W-1:0] cnt_q;
  logic              poison_q;

  logic        hit;
  logic        last_beat;
  logic        start_refill;
  logic        we;
  logic [31:0] rd_data;

  assign hit          = (state_q == IDLE) && valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign last_beat    = (cnt_q == WOFF_W'(LINE_WORDS - 1));
  assign start_refill = (state_q == IDLE) && !hit && !i_inv;

  icache_data_ram #(
    .DEPTH  (NUM_LINES * LINE_WORDS),
    .ADDR_W (IDX_W + WOFF_W)
  ) u_data_ram (
    .Clk   (Clk),
    .we    (we),
    .waddr ({r_idx, cnt_q}),
    .wdata (mem_rdata),
    .raddr ({a_idx, a_word}),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_refill) state_d = REFILL;
      REFILL:  if (mem_ack && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lookup result and array write strobe
  always_comb begin
    Icache_bus_out            = '0;
    Icache_bus_out[IMISS_BIT] = 1'b1;
    we                        = (state_q == REFILL) && mem_ack;
    if (hit) Icache_bus_out = {1'b0, rd_data};
  end

  // Refill bus sequencing: request, beat address, beat counter, poison flag
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cnt_q    <= '0;
      poison_q <= 1'b0;
    end else if (start_refill) begin
      mem_req  <= 1'b1;
      mem_addr <= {Icache_addr_in[31:WOFF_W+2], {(WOFF_W+2){1'b0}}};
      cnt_q    <= '0;
      poison_q <= 1'b0;
    end else if (state_q == REFILL) begin
      if (i_inv) poison_q <= 1'b1;
      if (mem_ack) begin
        if (last_beat) begin
          mem_req <= 1'b0;
        end else begin
          cnt_q    <= cnt_q + 1'b1;
          mem_addr <= mem_addr + 32'd4;
        end
      end
    end
  end

  // Valid bits: flush on invalidate, drop the victim at refill start, set on a clean fill
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      valid_q <= '0;
    end else begin
      if (i_inv)             valid_q        <= '0;
      else if (start_refill) valid_q[a_idx] <= 1'b0;
      if (we && last_beat && !poison_q && !i_inv) valid_q[r_idx] <= 1'b1;
    end
  end

  // Tag store written on the final beat; no reset needed since valid gates it
  always_ff @(posedge Clk) begin
    if (we && last_beat) tag_q[r_idx] <= r_tag;
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench: a line-residency reference model predicts every output each cycle.
module tb_icache_direct_mapped;

  localparam int LW = 4;
  localparam int NL = 64;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] Icache_addr_in;
  logic [32:0] Icache_bus_out;
  logic        i_inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 Clk = ~Clk;

  icache_direct_mapped #(
    .LINE_WORDS (LW),
    .NUM_LINES  (NL)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Icache_addr_in (Icache_addr_in),
    .Icache_bus_out (Icache_bus_out),
    .i_inv          (i_inv),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: which line base address each index holds, plus refill progress.
  // phase: -1 idle, 0..LW-1 waiting for that beat, LW the one-cycle done slot.
  bit          res_v    [NL];
  logic [31:0] res_base [NL];
  int          phase    = -1;
  logic [31:0] ref_base = '0;
  bit          poison   = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w >= 32'h100 && w < 32'h110) return 32'hA0 + ((w - 32'h100) >> 2);
    return ((w * 32'h9E37_79B1) ^ 32'h1234_5678) | 32'h1;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'(LW * 4)) % 32'(NL));
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return (phase < 0) && res_v[idx_of(a)] && (res_base[idx_of(a)] == line_of(a));
  endfunction

  function automatic bit in_refill();
    return (phase >= 0) && (phase < LW);
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    logic [32:0] eb;
    if (Rst) begin
      check("bus_rst", Icache_bus_out, 33'h1_0000_0000);
      check("req_rst", {32'b0, mem_req}, 33'h0);
      check("addr_rst", {1'b0, mem_addr}, 33'h0);
    end else begin
      eb = m_hit(Icache_addr_in) ? {1'b0, mem_word(Icache_addr_in)} : 33'h1_0000_0000;
      check("bus", Icache_bus_out, eb);
      check("mem_req", {32'b0, mem_req}, {32'b0, in_refill()});
      if (in_refill())
        check("mem_addr", {1'b0, mem_addr}, {1'b0, ref_base + 32'(4 * phase)});
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NL; i++) res_v[i] = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs that were driven.
  task automatic update();
    bit h;
    int ri;
    if (Rst) begin
      clear_all();
      phase  = -1;
      poison = 1'b0;
    end else if (phase < 0) begin
      h = m_hit(Icache_addr_in);
      if (i_inv) clear_all();
      else if (!h) begin
        res_v[idx_of(Icache_addr_in)] = 1'b0;
        ref_base = line_of(Icache_addr_in);
        poison   = 1'b0;
        phase    = 0;
      end
    end else if (phase < LW) begin
      if (i_inv) begin
        clear_all();
        poison = 1'b1;
      end
      if (mem_ack) begin
        if (phase == LW - 1) begin
          ri = idx_of(ref_base);
          res_base[ri] = ref_base;
          res_v[ri]    = !poison;
          phase        = LW;
        end else begin
          phase++;
        end
      end
    end else begin
      if (i_inv) clear_all();
      phase = -1;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic inv, input logic ack);
    Icache_addr_in = a;
    i_inv          = inv;
    mem_ack        = ack;
    mem_rdata      = (ack && in_refill()) ? mem_word(ref_base + 32'(4 * phase)) : $urandom;
  endtask

  task automatic tick();
    @(negedge Clk);
    compare();
    @(posedge Clk);
    #1;
    update();
  endtask

  task automatic step(input logic [31:0] a, input logic inv, input logic ack);
    drive(a, inv, ack);
    tick();
  endtask

  // Run the current refill to completion (random ack gaps), then the done slot.
  task automatic finish_refill(input logic [31:0] a);
    int budget;
    budget = 200;
    while (in_refill() && budget > 0) begin
      step(a, 1'b0, 1'($urandom_range(0, 1)));
      budget--;
    end
    if (budget == 0) begin
      total++;
      $display("FAIL refill_timeout: got phase %0d required done", phase);
    end
    if (phase == LW) step(a, 1'b0, 1'b0);
  endtask

  initial begin
    int ix;
    logic [31:0] tg, a;
    logic [31:0] tags [4];
    tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h5; tags[3] = 32'h3F_FFFF;
    for (int i = 0; i < NL; i++) begin
      res_v[i]    = 1'b0;
      res_base[i] = '0;
    end

    // Reset state
    drive(32'h100, 1'b0, 1'b0);
    #1 Rst = 1'b1;
    #1;
    check("lit_reset_req", {32'b0, mem_req}, 33'h0);
    check("lit_reset_addr", {1'b0, mem_addr}, 33'h0);
    check("lit_reset_bus", Icache_bus_out, 33'h1_0000_0000);
    tick();
    tick();
    Rst = 1'b0;

    // 1: cold miss, four beats, LINE_WORDS+2 cycle penalty
    drive(32'h100, 1'b0, 1'b0);
    #1 check("lit_cold_miss", Icache_bus_out, 33'h1_0000_0000);
    tick();
    for (int k = 0; k < LW; k++) begin
      drive(32'h100, 1'b0, 1'b1);
      #1 check("lit_beat_addr", {1'b0, mem_addr}, {1'b0, 32'h100 + 32'(4 * k)});
      tick();
    end
    drive(32'h104, 1'b0, 1'b0);
    #1 check("lit_done_miss", Icache_bus_out, 33'h1_0000_0000);
    tick();
    drive(32'h104, 1'b0, 1'b0);
    #1 check("lit_hit_104", Icache_bus_out, {1'b0, 32'hA1});
    tick();

    // 2: hits without bus traffic, then a conflicting tag evicts the line
    drive(32'h100, 1'b0, 1'b0);
    #1 check("lit_hit_100", Icache_bus_out, {1'b0, 32'hA0});
    tick();
    step(32'h108, 1'b0, 1'b0);
    drive(32'h10C, 1'b0, 1'b0);
    #1 check("lit_hit_10c", Icache_bus_out, {1'b0, 32'hA3});
    check("lit_hit_noreq", {32'b0, mem_req}, 33'h0);
    tick();
    step(32'h500, 1'b0, 1'b0);
    finish_refill(32'h500);
    drive(32'h100, 1'b0, 1'b0);
    #1 check("lit_evicted_miss", Icache_bus_out, 33'h1_0000_0000);
    tick();

    // 3: ack stall mid-refill and a wandering fetch address
    step(32'h100, 1'b0, 1'b1);
    step(32'h100, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(32'h200, 1'b0, 1'b0);
    drive(32'h200, 1'b0, 1'b0);
    #1 check("lit_stall_addr", {1'b0, mem_addr}, {1'b0, 32'h108});
    check("lit_stall_req", {32'b0, mem_req}, 33'h1);
    tick();
    step(32'h200, 1'b0, 1'b1);
    step(32'h200, 1'b0, 1'b1);
    step(32'h200, 1'b0, 1'b0);
    drive(32'h100, 1'b0, 1'b0);
    #1 check("lit_refilled_100", Icache_bus_out, {1'b0, 32'hA0});
    tick();

    // 4: invalidate in IDLE uses old valid bits, then invalidate during refill poisons
    drive(32'h108, 1'b1, 1'b0);
    #1 check("lit_inv_same_cycle", Icache_bus_out, {1'b0, 32'hA2});
    tick();
    drive(32'h100, 1'b0, 1'b0);
    #1 check("lit_after_inv", Icache_bus_out, 33'h1_0000_0000);
    tick();
    step(32'h100, 1'b0, 1'b1);
    step(32'h100, 1'b1, 1'b1);
    step(32'h100, 1'b0, 1'b1);
    step(32'h100, 1'b0, 1'b1);
    step(32'h100, 1'b0, 1'b0);
    drive(32'h100, 1'b0, 1'b0);
    #1 check("lit_poisoned", Icache_bus_out, 33'h1_0000_0000);
    tick();
    finish_refill(32'h100);

    // 5: reset at beat 2 aborts the refill immediately
    step(32'h100, 1'b1, 1'b0);
    step(32'h100, 1'b0, 1'b0);
    step(32'h100, 1'b0, 1'b1);
    step(32'h100, 1'b0, 1'b1);
    drive(32'h100, 1'b0, 1'b1);
    Rst = 1'b1;
    #1 check("lit_rst_abort_req", {32'b0, mem_req}, 33'h0);
    tick();
    tick();
    Rst = 1'b0;
    drive(32'h100, 1'b0, 1'b0);
    #1 check("lit_rst_miss", Icache_bus_out, 33'h1_0000_0000);
    tick();
    finish_refill(32'h100);

    // 6: random fetch stream over a few aliasing tags
    for (int n = 0; n < 3000; n++) begin
      ix = $urandom_range(0, 8);
      if (ix == 8) ix = 16;
      tg = tags[$urandom_range(0, 3)];
      a  = (tg << 10) | (32'(ix) << 4) | ($urandom & 32'hF);
      step(a, 1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 70));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
